gestor_alarmas_bateria: RTL and testbench
=========================================

Name: gestor_alarmas_bateria

Overview:
- Sequential stage directly downstream of the battery monitor. It consumes the per-battery discharge warnings and the one-hot charge-level flags.
- Filters glitches out of those signals and runs an alarm state machine with operator acknowledge.
- Drives the alarm LED (blink patterns), the buzzer, and a status code for the display logic.

Parameters:
- N_ESTABLE, 4, consecutive clk cycles an input pattern must hold before it is accepted (≥2).
- DIV_PARPADEO, 8, LED blink base period in clk cycles (even, ≥2).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- advertencia_bateria_1  input  1  battery 1 discharged warning.
- advertencia_bateria_2  input  1  battery 2 discharged warning.
- optimo  input  1  level flag.
- aceptable  input  1  level flag.
- regular  input  1  level flag.
- critico  input  1  level flag.
- reconocer  input  1  operator acknowledge, single-cycle or level.
- nivel_estable  output  2  filtered level: 00 optimo, 01 aceptable, 10 regular, 11 critico.
- advertencia_estable  output  1  filtered OR of both warnings.
- estado_alarma  output  2  FSM state code.
- led_alarma  output  1  alarm LED.
- buzzer  output  1  buzzer enable.

Behaviour:
- Reset: asynchronous assert. All outputs 0, FSM NORMAL, filter counter and candidate 0, blink counter and phases 0.
- Level encode (combinational), priority critico > regular > aceptable > optimo.
  - No flag set encodes as 11, critico (fail-safe).
  - Multiple flags set resolve by priority.
- Raw vector is {advertencia_bateria_1|advertencia_bateria_2, encoded level}, 3 bits.
- Filter, per rising edge:
  - If raw ≠ candidate: candidate<=raw, cnt<=0.
  - Else if cnt==N_ESTABLE-1: {advertencia_estable, nivel_estable}<=candidate; cnt holds.
  - Else: cnt<=cnt+1.
  - Latency: a new input pattern held steady appears on the outputs N_ESTABLE+1 edges after it is first present. Any single-cycle glitch restarts the count.
- FSM states:
  - NORMAL 00
  - AVISO 01
  - CRITICO 10
  - SILENCIADO 11
- FSM transitions, evaluated on filtered signals only:
  - NORMAL: nivel==11 -> CRITICO; else nivel==10 or advertencia_estable -> AVISO.
  - AVISO: nivel==11 -> CRITICO; else neither regular nor advertencia -> NORMAL.
  - CRITICO: reconocer -> SILENCIADO. Critico takes priority over reconocer on the entry cycle: reconocer is only sampled while already in CRITICO.
  - SILENCIADO: stays while nivel==11. Otherwise -> AVISO if regular or advertencia, else NORMAL. A later return to critico re-enters CRITICO.
  - Leaving CRITICO without acknowledge (level recovers): same exit rule as SILENCIADO.
  - reconocer has no effect in NORMAL or AVISO.
- Blink generator:
  - Free-running counter 0..DIV_PARPADEO-1, wraps to 0.
  - fase_rapida toggles when counter == DIV_PARPADEO/2-1 and when counter == DIV_PARPADEO-1.
  - fase_lenta toggles only when counter == DIV_PARPADEO-1.
- Outputs, registered, one cycle after the state/phase update:
  - NORMAL: led 0, buzzer 0.
  - AVISO: led = fase_lenta (period 2·DIV_PARPADEO), buzzer 0.
  - CRITICO: led = fase_rapida (period DIV_PARPADEO), buzzer 1.
  - SILENCIADO: led 1, buzzer 0.
- Reset mid-operation: immediate return to reset values. Critico must then re-qualify through the filter before it is asserted again.

Optional Feature:
- Macro REGISTRO_EVENTOS_EN.
- Defined:
  - Adds output contador_criticos [7:0], reset 0.
  - Increments on every transition into CRITICO from any other state.
  - Saturates at 255.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package bateria_pkg holds:
  - Level encodings NIVEL_OPTIMO/ACEPTABLE/REGULAR/CRITICO.
  - FSM state encodings EST_NORMAL/AVISO/CRITICO/SILENCIADO.
  - Width of contador_criticos.
- One sub-module, filtro_estabilidad: generic-width stability filter, parameters ANCHO and N_ESTABLE, instantiated with ANCHO=3.
- FSM and blink logic stay in the top module.

Test Plan (N_ESTABLE=4, DIV_PARPADEO=8):
- Reset with critico=1 held: all outputs 0. nivel_estable=11 and estado=10 appear 5 edges after rst falls; buzzer=1 one edge later.
- Filter: aceptable steady, regular pulsed for 3 cycles -> nivel_estable stays 01. Regular held for 4 cycles -> 10, then estado=01 and led toggles every 8 cycles.
- Critico plus reconocer pulse -> estado 10->11, buzzer 0, led solid 1. Level to optimo -> estado 00. Critico again -> 10.
- No level flag asserted (all 0) for 5 cycles -> nivel_estable=11, CRITICO entered.
- advertencia_bateria_2=1 with optimo -> AVISO. Warning removed -> NORMAL after filter latency. reconocer in AVISO -> no change.
- REGISTRO_EVENTOS_EN: 300 critico entries -> contador_criticos=255. Async rst mid-CRITICO -> all outputs and the counter go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/bateria_pkg.sv
// Shared encodings for the battery alarm manager: filtered level codes, alarm FSM
// state codes, event-counter width and the common "leave critical" exit rule.
package bateria_pkg;

   // Filtered level codes (nivel_estable)
   localparam logic [1:0] NIVEL_OPTIMO    = 2'b00;
   localparam logic [1:0] NIVEL_ACEPTABLE = 2'b01;
   localparam logic [1:0] NIVEL_REGULAR   = 2'b10;
   localparam logic [1:0] NIVEL_CRITICO   = 2'b11;

   // Alarm FSM state codes (estado_alarma)
   typedef enum logic [1:0] {
      EST_NORMAL     = 2'b00,
      EST_AVISO      = 2'b01,
      EST_CRITICO    = 2'b10,
      EST_SILENCIADO = 2'b11
   } estado_t;

   // Width of the optional critical-entry counter
   localparam int unsigned ANCHO_CONTADOR = 8;

   // Destination when the level is no longer critical: warn if regular or a battery warning
   function automatic estado_t estado_salida(input logic [1:0] nivel, input logic advertencia);
      return ((nivel == NIVEL_REGULAR) || advertencia) ? EST_AVISO : EST_NORMAL;
   endfunction

endpackage

// File: rtl/filtro_estabilidad.sv
// Generic stability filter: an input pattern is accepted only after it has been
// seen unchanged for N_ESTABLE consecutive edges. Any change restarts the count.
// salida_sig exposes the value salida takes on the next edge so downstream state
// can update on the same edge as the filtered output.
module filtro_estabilidad
   import bateria_pkg::*;
#(
   parameter int unsigned ANCHO     = 3,
   parameter int unsigned N_ESTABLE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ANCHO-1:0] entrada,
   output logic [ANCHO-1:0] salida,
   output logic [ANCHO-1:0] salida_sig
);

   localparam int unsigned ANCHO_CNT = $clog2(N_ESTABLE);
   localparam logic [ANCHO_CNT-1:0] CNT_MAX = ANCHO_CNT'(N_ESTABLE - 1);

   logic [ANCHO-1:0]     candidato_q, candidato_d;
   logic [ANCHO-1:0]     salida_q, salida_d;
   logic [ANCHO_CNT-1:0] cnt_q, cnt_d;

   // Next-state: restart on change, publish once the count reaches its limit
   always_comb begin
      candidato_d = candidato_q;
      cnt_d       = cnt_q;
      salida_d    = salida_q;
      if (entrada != candidato_q) begin
         candidato_d = entrada;
         cnt_d       = '0;
      end else if (cnt_q == CNT_MAX) begin
         salida_d = candidato_q;
      end else begin
         cnt_d = cnt_q + ANCHO_CNT'(1);
      end
   end

   // Filter state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         candidato_q <= '0;
         cnt_q       <= '0;
         salida_q    <= '0;
      end else begin
         candidato_q <= candidato_d;
         cnt_q       <= cnt_d;
         salida_q    <= salida_d;
      end
   end

   assign salida     = salida_q;
   assign salida_sig = salida_d;

endmodule

// File: rtl/gestor_alarmas_bateria.sv
// Battery alarm manager: filters the battery monitor's level flags and discharge
// warnings, runs the alarm FSM with operator acknowledge and drives LED blink
// patterns, the buzzer and the state code for the display.
// Optional: define REGISTRO_EVENTOS_EN to add the saturating contador_criticos output.
module gestor_alarmas_bateria
   import bateria_pkg::*;
#(
   parameter int unsigned N_ESTABLE    = 4,
   parameter int unsigned DIV_PARPADEO = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       advertencia_bateria_1,
   input  logic       advertencia_bateria_2,
   input  logic       optimo,
   input  logic       aceptable,
   input  logic       regular,
   input  logic       critico,
   input  logic       reconocer,
   output logic [1:0] nivel_estable,
   output logic       advertencia_estable,
   output logic [1:0] estado_alarma,
   output logic       led_alarma,
   output logic       buzzer
`ifdef REGISTRO_EVENTOS_EN
   ,
   output logic [ANCHO_CONTADOR-1:0] contador_criticos
`endif
);

   localparam int unsigned ANCHO_DIV = $clog2(DIV_PARPADEO);
   localparam logic [ANCHO_DIV-1:0] DIV_MITAD = ANCHO_DIV'(DIV_PARPADEO / 2 - 1);
   localparam logic [ANCHO_DIV-1:0] DIV_FIN   = ANCHO_DIV'(DIV_PARPADEO - 1);

   logic [1:0]           nivel_codificado;
   logic [2:0]           crudo;
   logic [2:0]           filtrado_q, filtrado_d;
   logic [1:0]           nivel_sig;
   logic                 advertencia_sig;
   estado_t              estado_q;
   logic [ANCHO_DIV-1:0] div_q;
   logic                 fase_rapida_q, fase_lenta_q;

   // Priority level encode; no flag at all is treated as critical (fail-safe)
   always_comb begin
      nivel_codificado = NIVEL_CRITICO;
      if (critico)        nivel_codificado = NIVEL_CRITICO;
      else if (regular)   nivel_codificado = NIVEL_REGULAR;
      else if (aceptable) nivel_codificado = NIVEL_ACEPTABLE;
      else if (optimo)    nivel_codificado = NIVEL_OPTIMO;
   end

   assign crudo = {advertencia_bateria_1 | advertencia_bateria_2, nivel_codificado};

   filtro_estabilidad #(
      .ANCHO     (3),
      .N_ESTABLE (N_ESTABLE)
   ) u_filtro (
      .clk        (clk),
      .rst        (rst),
      .entrada    (crudo),
      .salida     (filtrado_q),
      .salida_sig (filtrado_d)
   );

   assign advertencia_estable = filtrado_q[2];
   assign nivel_estable       = filtrado_q[1:0];

   // FSM sees the filtered value being published this edge, so state tracks it in step
   assign nivel_sig       = filtrado_d[1:0];
   assign advertencia_sig = filtrado_d[2];

   // Alarm FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= EST_NORMAL;
      end else begin
         unique case (estado_q)
            EST_NORMAL, EST_AVISO: begin
               estado_q <= (nivel_sig == NIVEL_CRITICO) ? EST_CRITICO
                                                       : estado_salida(nivel_sig, advertencia_sig);
            end
            EST_CRITICO: begin
               // Level recovery wins over a simultaneous acknowledge
               if (nivel_sig != NIVEL_CRITICO) estado_q <= estado_salida(nivel_sig, advertencia_sig);
               else if (reconocer)             estado_q <= EST_SILENCIADO;
            end
            EST_SILENCIADO: begin
               if (nivel_sig != NIVEL_CRITICO) estado_q <= estado_salida(nivel_sig, advertencia_sig);
            end
            default: estado_q <= EST_NORMAL;
         endcase
      end
   end

   assign estado_alarma = estado_q;

   // Free-running blink divider with fast (period DIV) and slow (period 2*DIV) phases
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q         <= '0;
         fase_rapida_q <= 1'b0;
         fase_lenta_q  <= 1'b0;
      end else begin
         if (div_q == DIV_FIN) begin
            div_q         <= '0;
            fase_rapida_q <= ~fase_rapida_q;
            fase_lenta_q  <= ~fase_lenta_q;
         end else begin
            div_q <= div_q + ANCHO_DIV'(1);
            if (div_q == DIV_MITAD) fase_rapida_q <= ~fase_rapida_q;
         end
      end
   end

   // Registered LED and buzzer, one cycle behind state and phases
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_alarma <= 1'b0;
         buzzer     <= 1'b0;
      end else begin
         unique case (estado_q)
            EST_NORMAL: begin
               led_alarma <= 1'b0;
               buzzer     <= 1'b0;
            end
            EST_AVISO: begin
               led_alarma <= fase_lenta_q;
               buzzer     <= 1'b0;
            end
            EST_CRITICO: begin
               led_alarma <= fase_rapida_q;
               buzzer     <= 1'b1;
            end
            EST_SILENCIADO: begin
               led_alarma <= 1'b1;
               buzzer     <= 1'b0;
            end
            default: begin
               led_alarma <= 1'b0;
               buzzer     <= 1'b0;
            end
         endcase
      end
   end

`ifdef REGISTRO_EVENTOS_EN
   logic                      entra_critico;
   logic [ANCHO_CONTADOR-1:0] contador_q;

   // Only NORMAL and AVISO can step into CRITICO (SILENCIADO holds while critical)
   assign entra_critico = ((estado_q == EST_NORMAL) || (estado_q == EST_AVISO)) &&
                          (nivel_sig == NIVEL_CRITICO);

   // Saturating count of entries into CRITICO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         contador_q <= '0;
      end else if (entra_critico && (contador_q != '1)) begin
         contador_q <= contador_q + ANCHO_CONTADOR'(1);
      end
   end

   assign contador_criticos = contador_q;
`endif

endmodule

// File: tb/tb_gestor_alarmas_bateria.sv
// Directed bench for gestor_alarmas_bateria (N_ESTABLE=4, DIV_PARPADEO=8).
// Define REGISTRO_EVENTOS_EN to also exercise contador_criticos.
module tb_gestor_alarmas_bateria;

   logic       clk = 1'b0;
   logic       rst;
   logic       advertencia_bateria_1, advertencia_bateria_2;
   logic       optimo, aceptable, regular, critico, reconocer;
   logic [1:0] nivel_estable;
   logic       advertencia_estable;
   logic [1:0] estado_alarma;
   logic       led_alarma;
   logic       buzzer;
`ifdef REGISTRO_EVENTOS_EN
   logic [7:0] contador_criticos;
`endif

   int num_comprobaciones = 0;
   int num_fallos         = 0;

   gestor_alarmas_bateria #(
      .N_ESTABLE    (4),
      .DIV_PARPADEO (8)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .advertencia_bateria_1 (advertencia_bateria_1),
      .advertencia_bateria_2 (advertencia_bateria_2),
      .optimo                (optimo),
      .aceptable             (aceptable),
      .regular               (regular),
      .critico               (critico),
      .reconocer             (reconocer),
      .nivel_estable         (nivel_estable),
      .advertencia_estable   (advertencia_estable),
      .estado_alarma         (estado_alarma),
      .led_alarma            (led_alarma),
      .buzzer                (buzzer)
`ifdef REGISTRO_EVENTOS_EN
      ,.contador_criticos    (contador_criticos)
`endif
   );

   always #5 clk = ~clk;

   task automatic comprobar(input string tag, input int observado, input int esperado);
      num_comprobaciones++;
      if (observado != esperado) begin
         num_fallos++;
         $display("FAIL %s: observed %0d, expected %0d", tag, observado, esperado);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit after the last edge
   task automatic ciclos(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic poner(input logic o, input logic a, input logic r, input logic c,
                        input logic w1, input logic w2);
      optimo = o; aceptable = a; regular = r; critico = c;
      advertencia_bateria_1 = w1; advertencia_bateria_2 = w2;
   endtask

   // Watch the LED for a bounded window and check the spacing of steady-state toggles
   task automatic medir_parpadeo(input string tag, input int ventana, input int intervalo);
      int   t[$];
      logic previo;
      previo = led_alarma;
      for (int i = 1; i <= ventana; i++) begin
         ciclos(1);
         if (led_alarma != previo) t.push_back(i);
         previo = led_alarma;
      end
      if (t.size() < 4) begin
         comprobar({tag, "_toggles"}, t.size(), 4);
      end else begin
         comprobar({tag, "_int1"}, t[2] - t[1], intervalo);
         comprobar({tag, "_int2"}, t[3] - t[2], intervalo);
      end
   endtask

   initial begin
      rst = 1'b1;
      reconocer = 1'b0;
      poner(0, 0, 0, 1, 0, 0);

      // Reset state with critico held
      ciclos(2);
      comprobar("rst_nivel", nivel_estable, 0);
      comprobar("rst_estado", estado_alarma, 0);
      comprobar("rst_led", led_alarma, 0);
      comprobar("rst_buzzer", buzzer, 0);
      comprobar("rst_adv", advertencia_estable, 0);
      rst = 1'b0;
      ciclos(4);
      comprobar("lat4_nivel", nivel_estable, 0);
      comprobar("lat4_estado", estado_alarma, 0);
      ciclos(1);
      comprobar("lat5_nivel", nivel_estable, 3);
      comprobar("lat5_estado", estado_alarma, 2);
      comprobar("lat5_buzzer", buzzer, 0);
      ciclos(1);
      comprobar("lat6_buzzer", buzzer, 1);
      comprobar("lat6_led", led_alarma, 1);

      // Acknowledge in CRITICO
      reconocer = 1'b1;
      ciclos(1);
      reconocer = 1'b0;
      comprobar("ack_estado", estado_alarma, 3);
      ciclos(1);
      comprobar("sil_buzzer", buzzer, 0);
      comprobar("sil_led", led_alarma, 1);

      // Recover to optimo from SILENCIADO
      poner(1, 0, 0, 0, 0, 0);
      ciclos(4);
      comprobar("sil_hold_estado", estado_alarma, 3);
      ciclos(1);
      comprobar("opt_nivel", nivel_estable, 0);
      comprobar("opt_estado", estado_alarma, 0);
      ciclos(1);
      comprobar("opt_led", led_alarma, 0);

      // Critico again, then recover without acknowledge
      poner(0, 0, 0, 1, 0, 0);
      ciclos(5);
      comprobar("recrit_estado", estado_alarma, 2);
      poner(1, 0, 0, 0, 0, 0);
      ciclos(5);
      comprobar("crit_exit_estado", estado_alarma, 0);

      // Glitch rejection: regular pulsed 3 cycles over steady aceptable
      poner(0, 1, 0, 0, 0, 0);
      ciclos(6);
      comprobar("acep_nivel", nivel_estable, 1);
      regular = 1'b1;
      ciclos(3);
      regular = 1'b0;
      ciclos(6);
      comprobar("glitch_nivel", nivel_estable, 1);
      comprobar("glitch_estado", estado_alarma, 0);

      // Regular held -> AVISO with slow blink
      regular = 1'b1;
      ciclos(4);
      comprobar("reg4_nivel", nivel_estable, 1);
      ciclos(1);
      comprobar("reg5_nivel", nivel_estable, 2);
      comprobar("aviso_estado", estado_alarma, 1);
      medir_parpadeo("aviso_led", 48, 8);
      comprobar("aviso_buzzer", buzzer, 0);

      // Acknowledge ignored in AVISO
      reconocer = 1'b1;
      ciclos(1);
      reconocer = 1'b0;
      ciclos(1);
      comprobar("aviso_ack_estado", estado_alarma, 1);

      // AVISO -> CRITICO with fast blink
      critico = 1'b1;
      ciclos(5);
      comprobar("aviso_crit_estado", estado_alarma, 2);
      medir_parpadeo("crit_led", 24, 4);
      comprobar("crit_buzzer", buzzer, 1);

      // No flags at all encodes as critico
      poner(1, 0, 0, 0, 0, 0);
      ciclos(6);
      comprobar("back_normal", estado_alarma, 0);
      poner(0, 0, 0, 0, 0, 0);
      ciclos(4);
      comprobar("noflag4_nivel", nivel_estable, 0);
      ciclos(1);
      comprobar("noflag5_nivel", nivel_estable, 3);
      comprobar("noflag5_estado", estado_alarma, 2);

      // Battery warning with optimo -> AVISO, then removal -> NORMAL
      poner(1, 0, 0, 0, 0, 1);
      ciclos(5);
      comprobar("warn_adv", advertencia_estable, 1);
      comprobar("warn_nivel", nivel_estable, 0);
      comprobar("warn_estado", estado_alarma, 1);
      advertencia_bateria_2 = 1'b0;
      ciclos(4);
      comprobar("unwarn4_estado", estado_alarma, 1);
      ciclos(1);
      comprobar("unwarn5_estado", estado_alarma, 0);
      comprobar("unwarn5_adv", advertencia_estable, 0);
      reconocer = 1'b1;
      ciclos(1);
      reconocer = 1'b0;
      ciclos(1);
      comprobar("normal_ack_estado", estado_alarma, 0);

      // Multiple flags resolve by priority
      poner(1, 1, 0, 0, 0, 0);
      ciclos(5);
      comprobar("prio_nivel", nivel_estable, 1);

`ifdef REGISTRO_EVENTOS_EN
      // Saturating critical-entry counter
      rst = 1'b1;
      #1;
      comprobar("cnt_rst", contador_criticos, 0);
      poner(0, 0, 0, 1, 0, 0);
      ciclos(1);
      rst = 1'b0;
      ciclos(5);
      comprobar("cnt_first", contador_criticos, 1);
      for (int i = 0; i < 299; i++) begin
         poner(1, 0, 0, 0, 0, 0);
         ciclos(6);
         poner(0, 0, 0, 1, 0, 0);
         ciclos(6);
         if (i == 9)   comprobar("cnt_11", contador_criticos, 11);
         if (i == 253) comprobar("cnt_255", contador_criticos, 255);
      end
      comprobar("cnt_sat", contador_criticos, 255);
`endif

      // Asynchronous reset in the middle of CRITICO
      poner(0, 0, 0, 1, 0, 0);
      ciclos(7);
      comprobar("pre_arst_estado", estado_alarma, 2);
      comprobar("pre_arst_buzzer", buzzer, 1);
      #3;
      rst = 1'b1;
      #1;
      comprobar("arst_estado", estado_alarma, 0);
      comprobar("arst_buzzer", buzzer, 0);
      comprobar("arst_nivel", nivel_estable, 0);
      comprobar("arst_led", led_alarma, 0);
`ifdef REGISTRO_EVENTOS_EN
      comprobar("arst_cnt", contador_criticos, 0);
`endif
      ciclos(1);
      rst = 1'b0;
      ciclos(4);
      comprobar("requal4_estado", estado_alarma, 0);
      ciclos(1);
      comprobar("requal5_estado", estado_alarma, 2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               num_comprobaciones, num_fallos);
      $finish;
   end

endmodule
